// File: rtl/calculator_top.sv
// calculator_top: 8-digit unsigned decimal calculator driven by 4-bit keypad
// commands. Supports add, subtract and shift-add multiply, and drives eight
// seven-segment digits plus a 2-bit status word.
module calculator_top #(
  parameter int NDIG = 8,
  parameter int W    = 27
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            cmd,
  output logic [NDIG-1:0][6:0]  displays,
  output logic [1:0]            status,
  output logic [2:0]            EA,
  output logic [2:0]            PE
);

  typedef enum logic [2:0] {
    OP1    = 3'd0,
    OP2    = 3'd1,
    CALC   = 3'd2,
    RESULT = 3'd3,
    ERROR  = 3'd4
  } stateE;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } opE;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam int              CW       = $clog2(W);
  localparam logic [W-1:0]    LIMIT    = W'(pow10(NDIG - 1));
  localparam logic [2*W-1:0]  MAXW     = (2*W)'(pow10(NDIG) - 64'd1);
  localparam logic [W-1:0]    TEN      = W'(10);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);
  localparam logic [3:0]      CMD_NOP  = 4'hD;

  stateE            state_q, state_d;
  opE               op_q, op_d, cmdOp;
  logic [3:0]       prevCmd_q;
  logic [W-1:0]     op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic [2*W-1:0]   acc_q, acc_d, mcand_q, mcand_d, accNext, sumWide;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, isDigit, isOp, isEq, isBs;
  logic [W-1:0]     dispVal;
  logic [4*NDIG-1:0] bcd;

  // Append a decimal digit to a binary value: v*10 + d.
  function automatic logic [W-1:0] appendDigit(input logic [W-1:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + {{(W-4){1'b0}}, d};
  endfunction

  // Double-dabble binary-to-BCD conversion, fully combinational.
  function automatic logic [4*NDIG-1:0] toBcd(input logic [W-1:0] v);
    logic [4*NDIG-1:0] b;
    b = '0;
    for (int i = W - 1; i >= 0; i--) begin
      for (int d = 0; d < NDIG; d++) begin
        if (b[4*d +: 4] >= 4'd5) b[4*d +: 4] = b[4*d +: 4] + 4'd3;
      end
      b = {b[4*NDIG-2:0], v[i]};
    end
    return b;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign accept  = (cmd != prevCmd_q);
  assign isDigit = (cmd <= 4'd9);
  assign isOp    = (cmd == 4'hA) || (cmd == 4'hB) || (cmd == 4'hC);
  assign isEq    = (cmd == 4'hE);
  assign isBs    = (cmd == 4'hF);
  assign cmdOp   = (cmd == 4'hA) ? OP_ADD : ((cmd == 4'hB) ? OP_SUB : OP_MUL);

  assign EA = state_q;
  assign PE = state_d;

  // Next-state and datapath update, only acting on newly accepted commands.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sumWide  = {{W{1'b0}}, op1_q} + {{W{1'b0}}, op2_q};
    accNext  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    case (state_q)
      OP1: begin
        if (accept) begin
          if (isDigit) begin
            if (op1_q < LIMIT) op1_d = appendDigit(op1_q, cmd);
          end else if (isBs) begin
            op1_d = op1_q / TEN;
          end else if (isOp) begin
            op_d    = cmdOp;
            op2_d   = '0;
            state_d = OP2;
          end
        end
      end
      OP2: begin
        if (accept) begin
          if (isDigit) begin
            if (op2_q < LIMIT) op2_d = appendDigit(op2_q, cmd);
          end else if (isBs) begin
            op2_d = op2_q / TEN;
          end else if (isOp) begin
            op_d = cmdOp;
          end else if (isEq) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, op1_q};
            mplier_d = op2_q;
            cnt_d    = '0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        case (op_q)
          OP_ADD: begin
            if (sumWide > MAXW) begin
              state_d = ERROR;
            end else begin
              result_d = sumWide[W-1:0];
              state_d  = RESULT;
            end
          end
          OP_SUB: begin
            if (op2_q > op1_q) begin
              state_d = ERROR;
            end else begin
              result_d = op1_q - op2_q;
              state_d  = RESULT;
            end
          end
          default: begin
            acc_d    = accNext;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              if (accNext > MAXW) begin
                state_d = ERROR;
              end else begin
                result_d = accNext[W-1:0];
                state_d  = RESULT;
              end
            end
          end
        endcase
      end
      RESULT: begin
        if (accept) begin
          if (isDigit) begin
            op1_d   = {{(W-4){1'b0}}, cmd};
            state_d = OP1;
          end else if (isOp) begin
            op1_d   = result_q;
            op_d    = cmdOp;
            op2_d   = '0;
            state_d = OP2;
          end
        end
      end
      ERROR: begin
        if (accept && isDigit) begin
          op1_d   = {{(W-4){1'b0}}, cmd};
          state_d = OP1;
        end
      end
      default: state_d = OP1;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= OP1;
      op_q      <= OP_ADD;
      prevCmd_q <= CMD_NOP;
      op1_q     <= '0;
      op2_q     <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      prevCmd_q <= cmd;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end

  // Pick the value to show; CALC keeps showing op2, which it never modifies.
  always_comb begin
    case (state_q)
      OP1:          dispVal = op1_q;
      RESULT:       dispVal = result_q;
      default:      dispVal = op2_q;
    endcase
    bcd = toBcd(dispVal);
  end

  // Segment drive with leading-zero blanking, or a lone "E" on error.
  always_comb begin
    logic leading;
    leading  = 1'b1;
    displays = '0;
    if (state_q == ERROR) begin
      displays[0] = 7'b1111001;
    end else begin
      for (int d = NDIG - 1; d >= 0; d--) begin
        if (d != 0 && leading && bcd[4*d +: 4] == 4'd0) begin
          displays[d] = 7'b0000000;
        end else begin
          leading     = 1'b0;
          displays[d] = seg7(bcd[4*d +: 4]);
        end
      end
    end
  end

  // Status word decoded from the registered state.
  always_comb begin
    case (state_q)
      CALC:    status = 2'b01;
      RESULT:  status = 2'b10;
      ERROR:   status = 2'b11;
      default: status = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_calculator_top.sv
// tb_calculator_top: directed-vector bench for calculator_top with
// hand-computed expected values and an independent display model.
module tb_calculator_top;

  localparam int NDIG = 8;
  localparam int W    = 27;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_MUL = 4'hC;
  localparam logic [3:0] K_NOP = 4'hD;
  localparam logic [3:0] K_EQ  = 4'hE;
  localparam logic [3:0] K_BS  = 4'hF;

  localparam logic [6:0] SEG [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                       7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                       7'b1111111, 7'b1101111};
  localparam logic [63:0] DISP_E = 64'h79;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [3:0]            cmd   = 4'hD;
  logic [NDIG-1:0][6:0]  displays;
  logic [1:0]            status;
  logic [2:0]            EA;
  logic [2:0]            PE;

  int testsRun    = 0;
  int testsFailed = 0;
  int busy;

  always #5 clock = ~clock;

  calculator_top #(.NDIG(NDIG), .W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd),
    .displays (displays),
    .status   (status),
    .EA       (EA),
    .PE       (PE)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected segment pattern built by repeated division of a decimal value.
  function automatic logic [63:0] expDisp(input longint unsigned v);
    logic [63:0] r;
    r = '0;
    if (v == 0) begin
      r[6:0] = SEG[0];
    end else begin
      for (int d = 0; d < NDIG && v != 0; d++) begin
        r[7*d +: 7] = SEG[int'(v % 10)];
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] dispNow();
    return {8'd0, displays};
  endfunction

  task automatic applyStimulus(input logic [3:0] c, input int n);
    cmd = c;
    repeat (n) @(negedge clock);
  endtask

  task automatic pressKey(input logic [3:0] c);
    applyStimulus(c, 2);
    applyStimulus(K_NOP, 2);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    cmd   = K_NOP;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic waitNotBusy(output int nBusy);
    nBusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (status == 2'b01) nBusy++;
      else break;
    end
  endtask

  initial begin
    #1;
    checkOutput("async reset EA", 64'(EA), 64'd0);
    applyReset();
    checkOutput("reset status", 64'(status), 64'd0);
    checkOutput("reset display", dispNow(), expDisp(0));
    checkOutput("reset EA", 64'(EA), 64'd0);

    // 6 * 2 = with each command held for 10 cycles
    applyStimulus(4'd6, 10);
    checkOutput("held 6 accepted once", dispNow(), expDisp(6));
    applyStimulus(K_MUL, 10);
    checkOutput("OP2 EA", 64'(EA), 64'd1);
    applyStimulus(4'd2, 10);
    cmd = K_EQ;
    waitNotBusy(busy);
    checkOutput("mul busy cycles", 64'(busy), 64'(W));
    checkOutput("mul status", 64'(status), 64'd2);
    checkOutput("mul 6*2 display", dispNow(), expDisp(12));
    checkOutput("mul EA", 64'(EA), 64'd3);
    applyStimulus(K_NOP, 2);

    // 123 + 1 = 124, result within two cycles
    pressKey(4'd1); pressKey(4'd2); pressKey(4'd3);
    checkOutput("op1 123", dispNow(), expDisp(123));
    pressKey(K_ADD); pressKey(4'd1);
    cmd = K_EQ;
    @(negedge clock);
    checkOutput("add busy", 64'(status), 64'd1);
    @(negedge clock);
    checkOutput("add status", 64'(status), 64'd2);
    checkOutput("add 124", dispNow(), expDisp(124));
    applyStimulus(K_NOP, 2);

    // chaining: 124 * 2 = 248
    pressKey(K_MUL); pressKey(4'd2);
    cmd = K_EQ;
    waitNotBusy(busy);
    checkOutput("chain busy", 64'(busy), 64'(W));
    checkOutput("chain 248", dispNow(), expDisp(248));
    applyStimulus(K_NOP, 2);

    // 50 - 15 = 35, then 15 - 50 errors
    pressKey(4'd5); pressKey(4'd0); pressKey(K_SUB); pressKey(4'd1); pressKey(4'd5);
    cmd = K_EQ;
    repeat (2) @(negedge clock);
    checkOutput("sub 35", dispNow(), expDisp(35));
    checkOutput("sub EA", 64'(EA), 64'd3);
    applyStimulus(K_NOP, 2);
    pressKey(4'd1); pressKey(4'd5); pressKey(K_SUB); pressKey(4'd5); pressKey(4'd0);
    cmd = K_EQ;
    repeat (2) @(negedge clock);
    checkOutput("neg status", 64'(status), 64'd3);
    checkOutput("neg EA", 64'(EA), 64'd4);
    checkOutput("neg display E", dispNow(), DISP_E);
    applyStimulus(K_NOP, 2);

    // 456, backspace -> 45; equals ignored in OP1
    pressKey(4'd4); pressKey(4'd5); pressKey(4'd6); pressKey(K_BS);
    checkOutput("backspace 45", dispNow(), expDisp(45));
    pressKey(K_EQ);
    checkOutput("eq ignored EA", 64'(EA), 64'd0);
    checkOutput("eq ignored status", 64'(status), 64'd0);
    checkOutput("eq ignored display", dispNow(), expDisp(45));

    // eight 9s saturate entry, ninth ignored; +1 overflows
    applyReset();
    for (int i = 0; i < 8; i++) pressKey(4'd9);
    checkOutput("eight 9s", dispNow(), expDisp(99999999));
    pressKey(4'd9);
    checkOutput("ninth 9 ignored", dispNow(), expDisp(99999999));
    pressKey(K_ADD);
    checkOutput("OP2 shows 0", dispNow(), expDisp(0));
    pressKey(4'd1);
    cmd = K_EQ;
    repeat (2) @(negedge clock);
    checkOutput("overflow status", 64'(status), 64'd3);
    checkOutput("overflow EA", 64'(EA), 64'd4);
    applyStimulus(K_NOP, 2);

    // reset during multiply aborts immediately
    applyReset();
    pressKey(4'd7); pressKey(K_MUL); pressKey(4'd9);
    cmd = K_EQ;
    repeat (5) @(negedge clock);
    checkOutput("mid mul busy", 64'(status), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort EA", 64'(EA), 64'd0);
    checkOutput("abort status", 64'(status), 64'd0);
    checkOutput("abort display", dispNow(), expDisp(0));
    cmd = K_NOP;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    pressKey(4'd8); pressKey(4'd8);
    checkOutput("after abort 88", dispNow(), expDisp(88));
    checkOutput("after abort EA", 64'(EA), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
